// File: rtl/round_pkg.sv
// round_pkg
//   Shared constants and helpers for the round_flag lap-flag generator.
//   DEFAULT_BUFFER_WIDTH : default address width (buffer depth 2**width)
//   last_addr(width)     : highest address (all-ones) for a given width
`timescale 1ns/1ps
package round_pkg;

    localparam int DEFAULT_BUFFER_WIDTH = 4;

    // Highest address before the pointer wraps to zero.
    function automatic int unsigned last_addr(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/wrap_detect.sv
// wrap_detect
//   Combinational wrap-pulse detector for one FIFO pointer.
//   Ports:
//     strobe : push or pop strobe for this pointer
//     addr   : current (pre-increment) pointer address
//     wrap   : high when the strobe commits at the last address
`timescale 1ns/1ps
module wrap_detect
    import round_pkg::*;
#(
    parameter int AddrWidth = DEFAULT_BUFFER_WIDTH
) (
    input  logic                 strobe,
    input  logic [AddrWidth-1:0] addr,
    output logic                 wrap
);

    localparam logic [AddrWidth-1:0] LAST = AddrWidth'(last_addr(AddrWidth));

    assign wrap = strobe && (addr == LAST);

endmodule

// File: rtl/round_flag.sv
// round_flag
//   Lap flag for a circular buffer of 2**BufferWidth entries. Round is set
//   when the write pointer has wrapped once more than the read pointer, so
//   equal addresses can be decoded as Full (Round=1) or Empty (Round=0).
//   Ports:
//     clk    : rising-edge clock
//     rst    : synchronous active-high reset, clears Round (and Err)
//     Push   : write strobe, commits at W_Addr on this edge
//     Pop    : read strobe, commits at R_Addr on this edge
//     W_Addr : current write address (pre-increment)
//     R_Addr : current read address (pre-increment)
//     Round  : registered lap flag
//     Full   : Round && (W_Addr == R_Addr), combinational
//     Empty  : !Round && (W_Addr == R_Addr), combinational
//     Err    : sticky overflow/underflow flag, only when ROUND_ERR_EN is defined
//   Configuration macro: ROUND_ERR_EN
`timescale 1ns/1ps
module round_flag
    import round_pkg::*;
#(
    parameter int BufferWidth = DEFAULT_BUFFER_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   Push,
    input  logic                   Pop,
    input  logic [BufferWidth-1:0] W_Addr,
    input  logic [BufferWidth-1:0] R_Addr,
    output logic                   Round,
`ifdef ROUND_ERR_EN
    output logic                   Err,
`endif
    output logic                   Full,
    output logic                   Empty
);

    logic wwrap;
    logic rwrap;
    logic addr_eq;

    wrap_detect #(.AddrWidth(BufferWidth)) u_wwrap (
        .strobe (Push),
        .addr   (W_Addr),
        .wrap   (wwrap)
    );

    wrap_detect #(.AddrWidth(BufferWidth)) u_rwrap (
        .strobe (Pop),
        .addr   (R_Addr),
        .wrap   (rwrap)
    );

    // Each wrap flips the lap parity; simultaneous wraps cancel. No guarding
    // against illegal sequences here -- that belongs to the FIFO controller.
    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignment so every flop
        // samples pre-edge values regardless of process ordering.
        if (rst) begin
            Round <= 1'b0;
        end else begin
            Round <= Round ^ wwrap ^ rwrap;
        end
    end

`ifdef ROUND_ERR_EN
    logic err_event;

    // Writing past the reader a second time, or reading past the writer,
    // is flagged unless both pointers wrap together.
    assign err_event = ((wwrap && Round) || (rwrap && !Round)) && !(wwrap && rwrap);

    always_ff @(posedge clk) begin
        if (rst) begin
            Err <= 1'b0;
        end else if (err_event) begin
            Err <= 1'b1;
        end
    end
`endif

    assign addr_eq = (W_Addr == R_Addr);
    assign Full    = Round && addr_eq;
    assign Empty   = !Round && addr_eq;

endmodule

// File: tb/tb_round_flag.sv
// tb_round_flag
//   Directed self-checking bench for round_flag (BufferWidth = 4, LAST = 15).
//   Err checks are included when ROUND_ERR_EN is defined.
`timescale 1ns/1ps
module tb_round_flag;

    logic       clk = 1'b0;
    logic       rst;
    logic       Push;
    logic       Pop;
    logic [3:0] W_Addr;
    logic [3:0] R_Addr;
    logic       Round;
    logic       Full;
    logic       Empty;
`ifdef ROUND_ERR_EN
    logic       Err;
`endif

    int passed = 0;
    int total  = 0;

    round_flag #(.BufferWidth(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .Push   (Push),
        .Pop    (Pop),
        .W_Addr (W_Addr),
        .R_Addr (R_Addr),
        .Round  (Round),
`ifdef ROUND_ERR_EN
        .Err    (Err),
`endif
        .Full   (Full),
        .Empty  (Empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic observed, input logic expected);
        total++;
        assert (observed === expected) passed++;
        else $error("FAIL %s: observed=%b expected=%b", tag, observed, expected);
    endtask

    // Apply the current inputs across one rising edge, then settle 1 ns.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic ps, input logic pp,
                         input logic [3:0] wa, input logic [3:0] ra);
        rst    = r;
        Push   = ps;
        Pop    = pp;
        W_Addr = wa;
        R_Addr = ra;
    endtask

    initial begin
        // Reset with equal addresses -> empty.
        drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        step();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        #1;
        check("reset_round", Round, 1'b0);
        check("reset_empty", Empty, 1'b1);
        check("reset_full",  Full,  1'b0);
`ifdef ROUND_ERR_EN
        check("reset_err", Err, 1'b0);
`endif

        // Idle hold.
        step();
        check("idle_hold", Round, 1'b0);

        // Write wrap alone: Round 0 -> 1, full at equal addresses.
        drive(1'b0, 1'b1, 1'b0, 4'd15, 4'd0);
        step();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        #1;
        check("wwrap_round", Round, 1'b1);
        check("wwrap_full",  Full,  1'b1);
        check("wwrap_empty", Empty, 1'b0);

        // Read wrap alone: Round 1 -> 0, empty at equal addresses.
        drive(1'b0, 1'b0, 1'b1, 4'd0, 4'd15);
        step();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        #1;
        check("rwrap_round", Round, 1'b0);
        check("rwrap_empty", Empty, 1'b1);
        check("rwrap_full",  Full,  1'b0);

        // Back to Round=1, then simultaneous wraps keep it.
        drive(1'b0, 1'b1, 1'b0, 4'd15, 4'd3);
        step();
        check("setup_round1", Round, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 4'd15, 4'd15);
        step();
        check("both_wrap_r1", Round, 1'b1);

        // Back to Round=0, then simultaneous wraps keep it.
        drive(1'b0, 1'b0, 1'b1, 4'd2, 4'd15);
        step();
        check("setup_round0", Round, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 4'd15, 4'd15);
        step();
        check("both_wrap_r0", Round, 1'b0);

        // Non-wrap traffic holds Round=0; unequal addresses -> neither flag.
        drive(1'b0, 1'b1, 1'b1, 4'd3, 4'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("nowrap_r0_%0d", i), Round, 1'b0);
        end
        check("neq_full",  Full,  1'b0);
        check("neq_empty", Empty, 1'b0);

        // Non-wrap traffic holds Round=1 as well.
        drive(1'b0, 1'b1, 1'b0, 4'd15, 4'd1);
        step();
        check("setup_round1b", Round, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 4'd3, 4'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("nowrap_r1_%0d", i), Round, 1'b1);
        end
        check("neq_full_r1", Full, 1'b0);

        // Reset wins over a simultaneous write wrap.
        drive(1'b1, 1'b1, 1'b0, 4'd15, 4'd0);
        step();
        drive(1'b0, 1'b0, 1'b0, 4'd5, 4'd5);
        #1;
        check("rst_priority_round", Round, 1'b0);
        check("rst_priority_empty", Empty, 1'b1);

        // Illegal read wrap at Round=0 still toggles Round.
        drive(1'b0, 1'b0, 1'b1, 4'd0, 4'd15);
        step();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        #1;
        check("underflow_round", Round, 1'b1);
`ifdef ROUND_ERR_EN
        check("underflow_err", Err, 1'b1);
        step();
        check("underflow_err_sticky", Err, 1'b1);

        // Reset clears Err; legal write wrap leaves it clear.
        drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        step();
        drive(1'b0, 1'b1, 1'b0, 4'd15, 4'd0);
        #1;
        check("err_cleared", Err, 1'b0);
        step();
        check("legal_wwrap_err", Err, 1'b0);
        check("legal_wwrap_round", Round, 1'b1);

        // Second write wrap while Round=1 -> overflow; Round still toggles.
        step();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        #1;
        check("overflow_err", Err, 1'b1);
        check("overflow_round", Round, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("overflow_sticky_%0d", i), Err, 1'b1);
        end
        drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        step();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        #1;
        check("err_rst_clear", Err, 1'b0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
